alu_host_if: RTL and testbench

Host-side command issuer and result collector for the FIFO-attached ALU.
- Accepts one ALU command per valid/ready handshake (opcode plus three arguments).
- Serializes each command into the ALU command FIFO as four words, in the order opcode, arg1, arg2, arg3.
- Pops results from the ALU result FIFO and presents them on a valid/ready response port, in command order.
- Limits commands in flight to MAX_OUTSTANDING.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_cmd_serializer.sv | 67 ++++++
 rtl/alu_host_if.sv | 106 ++++++++++
 tb/tb_alu_host_if.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the FIFO-attached ALU and its host interface.
// The ALU adopts the same opcode values and command word count.
`timescale 1ns/1ps
package alu_pkg;
  localparam logic [2:0] OP_ADD     = 3'd0;
  localparam logic [2:0] OP_MUL     = 3'd1;
  localparam logic [2:0] OP_MUL_ADD = 3'd2;

  localparam int CMD_WORDS = 4;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_PUSH = 2'd1,
    TX_GAP  = 2'd2
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_POP     = 2'd1,
    RX_CAPTURE = 2'd2,
    RX_HOLD    = 2'd3
  } rx_state_t;
endpackage

// File: rtl/alu_cmd_serializer.sv
// Latches one command and pushes it into the ALU command FIFO as
// opcode, arg1, arg2, arg3, leaving one idle cycle after every push.
`timescale 1ns/1ps
module alu_cmd_serializer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [2:0]            opcode,
  input  logic [DATA_WIDTH-1:0] arg1,
  input  logic [DATA_WIDTH-1:0] arg2,
  input  logic [DATA_WIDTH-1:0] arg3,
  input  logic                  cmd_full,
  output logic                  cmd_wr,
  output logic [DATA_WIDTH-1:0] cmd_dout,
  output tx_state_t             state,
  output tx_state_t             state_next
);

  logic [DATA_WIDTH-1:0] words [CMD_WORDS];
  logic [1:0]            idx;
  logic                  push;

  always_comb begin
    state_next = state;
    push       = 1'b0;
    case (state)
      TX_IDLE: if (start) state_next = TX_PUSH;
      TX_PUSH: begin
        if (!cmd_full) begin
          push       = 1'b1;
          state_next = TX_GAP;
        end
      end
      // The gap cycle lets cmd_full catch up with the push just made.
      TX_GAP:  state_next = (idx == 2'(CMD_WORDS - 1)) ? TX_IDLE : TX_PUSH;
      default: state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= TX_IDLE;
      cmd_wr   <= 1'b0;
      cmd_dout <= '0;
      idx      <= '0;
      for (int i = 0; i < CMD_WORDS; i++) words[i] <= '0;
    end else begin
      state    <= state_next;
      cmd_wr   <= push;
      cmd_dout <= push ? words[idx] : '0;
      if (start && state == TX_IDLE) begin
        words[0] <= {{(DATA_WIDTH-3){1'b0}}, opcode};
        words[1] <= arg1;
        words[2] <= arg2;
        words[3] <= arg3;
        idx      <= '0;
      end else if (state == TX_GAP && idx != 2'(CMD_WORDS - 1)) begin
        idx <= idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/alu_host_if.sv
// Host-side command issuer and in-order result collector for the FIFO ALU.
// Handshakes: a transfer happens on a rising clock edge where valid && ready.
`timescale 1ns/1ps
module alu_host_if
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_opcode,
  input  logic [DATA_WIDTH-1:0] req_arg1,
  input  logic [DATA_WIDTH-1:0] req_arg2,
  input  logic [DATA_WIDTH-1:0] req_arg3,
  input  logic                  cmd_full,
  output logic                  cmd_wr,
  output logic [DATA_WIDTH-1:0] cmd_dout,
  input  logic                  res_empty,
  output logic                  res_rd,
  input  logic [DATA_WIDTH-1:0] res_din,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [CNT_W-1:0]      outstanding
);

  tx_state_t        tx_state, tx_state_next;
  rx_state_t        rx_state, rx_state_next;
  logic             req_fire, rsp_fire, pop;
  logic [CNT_W-1:0] cnt_next;

  assign req_fire = req_valid && req_ready;
  assign rsp_fire = (rx_state == RX_HOLD) && rsp_ready;

  alu_cmd_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (req_fire),
    .opcode     (req_opcode),
    .arg1       (req_arg1),
    .arg2       (req_arg2),
    .arg3       (req_arg3),
    .cmd_full   (cmd_full),
    .cmd_wr     (cmd_wr),
    .cmd_dout   (cmd_dout),
    .state      (tx_state),
    .state_next (tx_state_next)
  );

  always_comb begin
    cnt_next = outstanding;
    case ({req_fire, rsp_fire})
      2'b10:   cnt_next = outstanding + CNT_W'(1);
      2'b01:   cnt_next = outstanding - CNT_W'(1);
      default: cnt_next = outstanding;
    endcase
  end

  // Spurious results (nothing outstanding) stay in the FIFO untouched.
  always_comb begin
    rx_state_next = rx_state;
    pop           = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!res_empty && outstanding != '0) begin
          pop           = 1'b1;
          rx_state_next = RX_POP;
        end
      end
      RX_POP:     rx_state_next = RX_CAPTURE;
      RX_CAPTURE: rx_state_next = RX_HOLD;
      RX_HOLD:    if (rsp_ready) rx_state_next = RX_IDLE;
      default:    rx_state_next = RX_IDLE;
    endcase
  end

  // req_ready is registered from next-state values so it equals the
  // idle/limit condition of the current cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_state    <= RX_IDLE;
      outstanding <= '0;
      req_ready   <= 1'b0;
      res_rd      <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
    end else begin
      rx_state    <= rx_state_next;
      outstanding <= cnt_next;
      req_ready   <= (tx_state_next == TX_IDLE) &&
                     (cnt_next < CNT_W'(MAX_OUTSTANDING));
      res_rd      <= pop;
      if (rx_state == RX_CAPTURE) begin
        rsp_data  <= res_din;
        rsp_valid <= 1'b1;
      end else if (rsp_fire) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_host_if.sv
// Bench for alu_host_if with a loopback command FIFO / ALU / result FIFO model.
`timescale 1ns/1ps
module tb_alu_host_if;
  import alu_pkg::*;

  localparam int DW   = 32;
  localparam int MAXO = 4;
  localparam int CW   = $clog2(MAXO + 1);

  logic          clock = 1'b0;
  logic          reset_n;
  logic          req_valid, req_ready;
  logic [2:0]    req_opcode;
  logic [DW-1:0] req_arg1, req_arg2, req_arg3;
  logic          cmd_full, cmd_wr;
  logic [DW-1:0] cmd_dout;
  logic          res_empty, res_rd;
  logic [DW-1:0] res_din;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [CW-1:0] outstanding;

  int total = 0;
  int bad   = 0;
  int push_cnt = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] cmd_exp_q[$];
  logic [DW-1:0] res_q[$];
  logic [DW-1:0] alu_words[$];
  logic [DW-1:0] last_res = '0;
  logic          prev_cmd_wr = 1'b0;
  logic          prev_res_rd = 1'b0;

  typedef struct {
    logic [2:0]    op;
    logic [DW-1:0] a1, a2, a3;
    logic [DW-1:0] res;
  } vec_t;

  vec_t vecs[6];

  alu_host_if #(.DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_opcode  (req_opcode),
    .req_arg1    (req_arg1),
    .req_arg2    (req_arg2),
    .req_arg3    (req_arg3),
    .cmd_full    (cmd_full),
    .cmd_wr      (cmd_wr),
    .cmd_dout    (cmd_dout),
    .res_empty   (res_empty),
    .res_rd      (res_rd),
    .res_din     (res_din),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .outstanding (outstanding)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Loopback model plus monitor: samples 1ns after the falling edge.
  always begin
    @(negedge clock);
    #1;
    if (!reset_n) begin
      res_q.delete();
      alu_words.delete();
      prev_cmd_wr = 1'b0;
      prev_res_rd = 1'b0;
    end else begin
      if (cmd_wr) begin
        if (cmd_exp_q.size() == 0) fail_now("cmd_word_unexpected");
        else check("cmd_word", cmd_dout, cmd_exp_q.pop_front());
        push_cnt++;
        alu_words.push_back(cmd_dout);
        if (alu_words.size() == CMD_WORDS) begin
          case (alu_words[0])
            DW'(OP_ADD):     last_res = alu_words[1] + alu_words[2];
            DW'(OP_MUL):     last_res = alu_words[1] * alu_words[2];
            DW'(OP_MUL_ADD): last_res = alu_words[1] * alu_words[2] + alu_words[3];
            default:         last_res = last_res;
          endcase
          res_q.push_back(last_res);
          alu_words.delete();
        end
      end else begin
        check("cmd_dout_idle_zero", cmd_dout, 0);
      end
      check("cmd_wr_spacing", prev_cmd_wr && cmd_wr, 0);
      check("res_rd_spacing", prev_res_rd && res_rd, 0);
      if (res_rd) begin
        if (res_q.size() == 0) fail_now("res_rd_on_empty");
        else res_din = res_q.pop_front();
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) fail_now("rsp_unexpected");
        else check("rsp_data", rsp_data, exp_q.pop_front());
      end
      check("outstanding_max", outstanding <= CW'(MAXO), 1);
      prev_cmd_wr = cmd_wr;
      prev_res_rd = res_rd;
    end
    res_empty = (res_q.size() == 0);
  end

  // driver tasks
  task automatic send(input logic [2:0] op, input logic [DW-1:0] a1, input logic [DW-1:0] a2,
                      input logic [DW-1:0] a3, input logic [DW-1:0] exp_res);
    int n = 0;
    @(negedge clock);
    req_valid = 1'b1; req_opcode = op; req_arg1 = a1; req_arg2 = a2; req_arg3 = a3;
    while (!req_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      fail_now("send_timeout");
      req_valid = 1'b0;
      return;
    end
    cmd_exp_q.push_back(DW'(op));
    cmd_exp_q.push_back(a1);
    cmd_exp_q.push_back(a2);
    cmd_exp_q.push_back(a3);
    exp_q.push_back(exp_res);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clock);
      #2;
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
    @(negedge clock);
  endtask

  task automatic wait_pushes(input int target);
    int n = 0;
    while (push_cnt < target && n < 200) begin
      @(negedge clock);
      #2;
      n++;
    end
    if (push_cnt < target) fail_now("push_timeout");
  endtask

  initial begin
    int k;
    int base;
    reset_n = 1'b0; req_valid = 1'b0; req_opcode = '0;
    req_arg1 = '0; req_arg2 = '0; req_arg3 = '0;
    cmd_full = 1'b0; rsp_ready = 1'b0; res_din = '0; res_empty = 1'b1;

    vecs[0] = '{OP_ADD,     32'd5,      32'd7,       32'd0,  32'd12};
    vecs[1] = '{OP_MUL_ADD, 32'd3,      32'd4,       32'd10, 32'd22};
    vecs[2] = '{OP_MUL,     32'h0000FFFF, 32'h00010001, 32'd0, 32'hFFFFFFFF};
    vecs[3] = '{OP_ADD,     32'hFFFFFFFF, 32'd1,     32'd9,  32'd0};
    vecs[4] = '{OP_MUL,     32'd6,      32'd7,       32'd3,  32'd42};
    vecs[5] = '{OP_MUL_ADD, 32'd2,      32'd3,       32'd1,  32'd7};

    repeat (3) @(negedge clock);
    check("reset_req_ready", req_ready, 0);
    check("reset_cmd_wr", cmd_wr, 0);
    check("reset_res_rd", res_rd, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_outstanding", outstanding, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_req_ready", req_ready, 1);

    // table-driven single commands
    for (int i = 0; i < 6; i++) begin
      rsp_ready = (i != 0);
      send(vecs[i].op, vecs[i].a1, vecs[i].a2, vecs[i].a3, vecs[i].res);
      if (i == 0) begin
        k = 0;
        do begin
          @(negedge clock);
          k++;
        end while (!req_ready && k < 50);
        check("req_ready_latency", k, 9);
        k = 0;
        while (!rsp_valid && k < 50) begin
          @(negedge clock);
          k++;
        end
        repeat (4) begin
          @(negedge clock);
          check("rsp_valid_hold", rsp_valid, 1);
          check("rsp_data_hold", rsp_data, vecs[0].res);
        end
        rsp_ready = 1'b1;
      end
      wait_drain();
      check("outstanding_after_vec", outstanding, 0);
    end

    // cmd_full held during arg2
    base = push_cnt;
    send(OP_ADD, 32'd9, 32'd8, 32'd7, 32'd17);
    wait_pushes(base + 2);
    cmd_full = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("cmd_wr_while_full", cmd_wr, 0);
    end
    cmd_full = 1'b0;
    wait_pushes(base + 4);
    wait_drain();
    check("push_count_full", push_cnt - base, 4);

    // fill to the outstanding limit, then drain
    rsp_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(OP_ADD, DW'(i), DW'(i), 32'd0, DW'(2 * i));
    @(negedge clock);
    check("req_ready_at_limit", req_ready, 0);
    check("outstanding_at_limit", outstanding, 4);
    repeat (15) @(negedge clock);
    check("req_ready_still_low", req_ready, 0);
    rsp_ready = 1'b1;
    #2;
    k = 0;
    while (exp_q.size() != 3 && k < 50) begin
      @(negedge clock);
      #2;
      k++;
    end
    @(negedge clock);
    check("req_ready_after_first_drain", req_ready, 1);
    wait_drain();

    // simultaneous request and response handshakes
    rsp_ready = 1'b0;
    send(OP_ADD, 32'd10, 32'd20, 32'd0, 32'd30);
    send(OP_ADD, 32'd5, 32'd6, 32'd0, 32'd11);
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!(rsp_valid && req_ready) && k < 60);
    check("outstanding_before_simul", outstanding, 2);
    req_valid = 1'b1; req_opcode = OP_ADD; req_arg1 = 32'd100; req_arg2 = 32'd1; req_arg3 = 32'd0;
    rsp_ready = 1'b1;
    cmd_exp_q.push_back(DW'(OP_ADD));
    cmd_exp_q.push_back(32'd100);
    cmd_exp_q.push_back(32'd1);
    cmd_exp_q.push_back(32'd0);
    exp_q.push_back(32'd101);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(negedge clock);
    rsp_ready = 1'b0;
    check("outstanding_simul", outstanding, 2);
    rsp_ready = 1'b1;
    wait_drain();

    // asynchronous reset in the middle of a command
    base = push_cnt;
    send(OP_ADD, 32'd3, 32'd3, 32'd0, 32'd6);
    wait_pushes(base + 1);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_cmd_wr", cmd_wr, 0);
    check("async_rst_res_rd", res_rd, 0);
    check("async_rst_rsp_valid", rsp_valid, 0);
    check("async_rst_outstanding", outstanding, 0);
    check("async_rst_req_ready", req_ready, 0);
    exp_q.delete();
    cmd_exp_q.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    send(OP_ADD, 32'd1, 32'd1, 32'd0, 32'd2);
    wait_drain();
    check("outstanding_after_reset_cmd", outstanding, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
